// File: rtl/fb_fill_pkg.sv
// Shared types and helpers for the rectangle-fill sequencer.
// The clip helper works on 32-bit values so that limit - origin can never wrap.
package fb_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EMIT  = 2'd2
    } fill_state_e;

    // Visible extent of a span starting at origin with the given size inside [0, limit).
    function automatic int unsigned clip_extent(input int unsigned origin,
                                                input int unsigned size,
                                                input int unsigned limit);
        int unsigned room;
        if (origin >= limit) begin
            return 0;
        end
        room = limit - origin;
        return (size < room) ? size : room;
    endfunction

endpackage

// File: rtl/fb_fill_clip.sv
// Combinational clip of a fill command against the frame buffer.
// A zero extent on either axis marks the command as empty.
module fb_fill_clip
    import fb_fill_pkg::*;
#(
    parameter int COORD_BITS = 10,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480
) (
    input  logic [COORD_BITS-1:0] x_i,
    input  logic [COORD_BITS-1:0] y_i,
    input  logic [COORD_BITS-1:0] w_i,
    input  logic [COORD_BITS-1:0] h_i,
    output logic [COORD_BITS-1:0] eff_w_o,
    output logic [COORD_BITS-1:0] eff_h_o,
    output logic                  empty_o
);

    assign eff_w_o = COORD_BITS'(clip_extent(32'(x_i), 32'(w_i), FB_WIDTH));
    assign eff_h_o = COORD_BITS'(clip_extent(32'(y_i), 32'(h_i), FB_HEIGHT));
    assign empty_o = (eff_w_o == '0) || (eff_h_o == '0);

endmodule

// File: rtl/fb_fill_rect.sv
// Rectangle-fill sequencer: walks a clipped rectangle row-major and emits one
// addr/color beat per pixel on a valid/ready stream.
module fb_fill_rect #(
    parameter int PIXEL_BITS     = 12,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int FB_WIDTH       = 640,
    parameter int FB_HEIGHT      = 480,
    parameter int COORD_BITS     = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [COORD_BITS-1:0]     cmd_x,
    input  logic [COORD_BITS-1:0]     cmd_y,
    input  logic [COORD_BITS-1:0]     cmd_w,
    input  logic [COORD_BITS-1:0]     cmd_h,
    input  logic [PIXEL_BITS-1:0]     cmd_color,
    output logic                      axi_tvalid,
    input  logic                      axi_tready,
    output logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [PIXEL_BITS-1:0]     color,
    output logic                      busy,
    output logic                      done
);
    import fb_fill_pkg::*;

    localparam logic [AXI_ADDR_WIDTH-1:0] ROW_STRIDE = AXI_ADDR_WIDTH'(FB_WIDTH);

    fill_state_e               state_q;
    logic                      cmd_ready_q, busy_q, done_q, tvalid_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, row_base_q;
    logic [PIXEL_BITS-1:0]     color_q;
    logic [COORD_BITS-1:0]     x_q, y_q, w_m1_q, h_m1_q, col_cnt_q, row_cnt_q;
    logic                      empty_q;

    logic [COORD_BITS-1:0]     eff_w, eff_h;
    logic                      empty;
    logic [AXI_ADDR_WIDTH-1:0] row_base_d, next_row_d;

    fb_fill_clip #(
        .COORD_BITS (COORD_BITS),
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT)
    ) u_clip (
        .x_i     (cmd_x),
        .y_i     (cmd_y),
        .w_i     (cmd_w),
        .h_i     (cmd_h),
        .eff_w_o (eff_w),
        .eff_h_o (eff_h),
        .empty_o (empty)
    );

    // The only multiply: constant stride, evaluated once per command in SETUP.
    assign row_base_d = AXI_ADDR_WIDTH'(y_q) * ROW_STRIDE + AXI_ADDR_WIDTH'(x_q);
    assign next_row_d = row_base_q + ROW_STRIDE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            addr_q      <= '0;
            color_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        x_q         <= cmd_x;
                        y_q         <= cmd_y;
                        w_m1_q      <= eff_w - COORD_BITS'(1);
                        h_m1_q      <= eff_h - COORD_BITS'(1);
                        empty_q     <= empty;
                        color_q     <= cmd_color;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    row_base_q <= row_base_d;
                    addr_q     <= row_base_d;
                    col_cnt_q  <= w_m1_q;
                    row_cnt_q  <= h_m1_q;
                    if (empty_q) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tvalid_q <= 1'b1;
                        state_q  <= EMIT;
                    end
                end
                EMIT: begin
                    if (axi_tready) begin
                        if (col_cnt_q != '0) begin
                            addr_q    <= addr_q + AXI_ADDR_WIDTH'(1);
                            col_cnt_q <= col_cnt_q - COORD_BITS'(1);
                        end else if (row_cnt_q != '0) begin
                            row_base_q <= next_row_d;
                            addr_q     <= next_row_d;
                            col_cnt_q  <= w_m1_q;
                            row_cnt_q  <= row_cnt_q - COORD_BITS'(1);
                        end else begin
                            tvalid_q    <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    tvalid_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign axi_tvalid = tvalid_q;
    assign addr       = addr_q;
    assign color      = color_q;

endmodule

// File: tb/tb_fb_fill_rect.sv
// Directed bench for fb_fill_rect: table of fill commands with hand-computed
// beat counts and end addresses, plus back-to-back and mid-fill reset sequences.
module tb_fb_fill_rect;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [11:0] cmd_color;
    logic        axi_tvalid;
    logic        axi_tready;
    logic [19:0] addr;
    logic [11:0] color;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int x, y, w, h;
        int col;
        int exp_beats;
        int exp_first;
        int exp_last;
        bit rnd_ready;
    } vec_t;

    always #5 clk = ~clk;

    fb_fill_rect dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .axi_tvalid (axi_tvalid),
        .axi_tready (axi_tready),
        .addr       (addr),
        .color      (color),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference walk: row-major over the clipped extent.
    function automatic int model_addr(input vec_t v, input int i);
        int ew;
        ew = (v.x >= 640) ? 0 : ((v.w < 640 - v.x) ? v.w : 640 - v.x);
        return (v.y + i / ew) * 640 + v.x + i % ew;
    endfunction

    // Outputs must hold while a beat is offered but not taken.
    logic        pv_stall = 1'b0;
    logic [19:0] p_addr;
    logic [11:0] p_col;
    always @(negedge clk) begin
        if (pv_stall) begin
            check("stall_tvalid", axi_tvalid, 1);
            check("stall_addr", addr, p_addr);
            check("stall_color", color, p_col);
        end
        pv_stall <= axi_tvalid && !axi_tready && !reset;
        p_addr   <= addr;
        p_col    <= color;
    end

    task automatic drive_cmd(input vec_t v);
        cmd_x     = 10'(v.x);
        cmd_y     = 10'(v.y);
        cmd_w     = 10'(v.w);
        cmd_h     = 10'(v.h);
        cmd_color = 12'(v.col);
        cmd_valid = 1'b1;
    endtask

    // Holds cmd_valid until the handshake edge; returns just after that edge.
    task automatic accept(input string name);
        bit hs = 0;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk); #1;
        end
        if (!hs) check({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic run_fill(input string name, input vec_t v);
        int beats = 0, tv_c = 0, last_c = 0, done_c = 0, last_a = -1;
        @(posedge clk); #1;
        drive_cmd(v);
        accept(name);
        cmd_valid  = 1'b0;
        axi_tready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 1; c <= 3000 && done_c == 0; c++) begin
            @(negedge clk);
            if (c == 1) check({name, "_busy"}, busy, 1);
            if (axi_tvalid && tv_c == 0) tv_c = c;
            if (axi_tvalid && axi_tready) begin
                if (beats == 0) check({name, "_first_addr"}, addr, v.exp_first);
                check({name, "_addr"}, addr, model_addr(v, beats));
                check({name, "_color"}, color, v.col);
                last_a = addr;
                last_c = c;
                beats++;
            end
            if (done) begin
                done_c = c;
                check({name, "_done_busy"}, busy, 0);
                check({name, "_done_ready"}, cmd_ready, 1);
            end
            @(posedge clk); #1;
            axi_tready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check({name, "_beats"}, beats, v.exp_beats);
        if (v.exp_beats == 0) begin
            check({name, "_empty_done_cycle"}, done_c, 2);
        end else begin
            check({name, "_first_tvalid_cycle"}, tv_c, 2);
            check({name, "_last_addr"}, last_a, v.exp_last);
            check({name, "_done_cycle"}, done_c, last_c + 1);
        end
        @(negedge clk);
        check({name, "_done_pulse_width"}, done, 0);
        check({name, "_idle_busy"}, busy, 0);
    endtask

    vec_t vecs[12];
    vec_t va, vb, v8;

    initial begin
        vecs[0]  = '{2,   1,   3,   2,   'hF00, 6,    642,    1284,   0};
        vecs[1]  = '{638, 479, 5,   5,   'h0AB, 2,    307198, 307199, 0};
        vecs[2]  = '{0,   0,   1,   1,   'h123, 1,    0,      0,      0};
        vecs[3]  = '{639, 0,   1,   3,   'h456, 3,    639,    1919,   0};
        vecs[4]  = '{0,   478, 640, 2,   'hFFF, 1280, 305920, 307199, 0};
        vecs[5]  = '{5,   5,   0,   3,   'h111, 0,    -1,     -1,     0};
        vecs[6]  = '{640, 0,   4,   4,   'h222, 0,    -1,     -1,     0};
        vecs[7]  = '{0,   480, 4,   4,   'h333, 0,    -1,     -1,     0};
        vecs[8]  = '{10,  20,  4,   1,   'h789, 4,    12810,  12813,  0};
        vecs[9]  = '{100, 200, 1,   3,   'hABC, 3,    128100, 129380, 0};
        vecs[10] = '{5,   5,   4,   4,   'h5A5, 16,   3205,   5128,   1};
        vecs[11] = '{637, 478, 4,   4,   'h0F0, 6,    306557, 307199, 1};

        reset = 1'b1; cmd_valid = 1'b0; axi_tready = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", axi_tvalid, 0);
        check("rst_addr", addr, 0);
        check("rst_color", color, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 12; i++) run_fill($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back: second command waits with valid high through the first.
        va = '{2, 1, 3, 2, 'hF00, 6, 642, 1284, 0};
        vb = '{10, 20, 4, 1, 'h789, 4, 12810, 12813, 0};
        @(posedge clk); #1;
        axi_tready = 1'b1;
        drive_cmd(va);
        accept("b2b_a");
        drive_cmd(vb);
        begin
            bit acc = 0;
            int tv_c = 0;
            for (int c = 0; c < 100 && !acc; c++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    acc = 1;
                    check("b2b_accept_on_done", done, 1);
                end
                @(posedge clk); #1;
            end
            if (!acc) check("b2b_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            for (int c = 1; c <= 4 && tv_c == 0; c++) begin
                @(negedge clk);
                if (axi_tvalid) begin
                    tv_c = c;
                    check("b2b_second_first_addr", addr, 12810);
                    check("b2b_second_color", color, 'h789);
                end
            end
            check("b2b_second_tvalid_cycle", tv_c, 2);
            acc = 0;
            for (int c = 0; c < 50 && !acc; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                acc = done;
            end
            check("b2b_second_done", acc, 1);
        end

        // Reset after the third beat of an 8x8 fill.
        v8 = '{0, 0, 8, 8, 'h5A5, 64, 0, 4487, 0};
        @(posedge clk); #1;
        axi_tready = 1'b1;
        drive_cmd(v8);
        accept("rst8");
        cmd_valid = 1'b0;
        begin
            int beats = 0;
            bit saw_done = 0;
            for (int c = 0; c < 20 && beats < 3; c++) begin
                @(negedge clk);
                if (axi_tvalid && axi_tready) beats++;
                @(posedge clk); #1;
            end
            check("rst8_three_beats", beats, 3);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("rst8_tvalid", axi_tvalid, 0);
            check("rst8_busy", busy, 0);
            check("rst8_cmd_ready", cmd_ready, 1);
            check("rst8_addr", addr, 0);
            for (int c = 0; c < 6; c++) begin
                if (done) saw_done = 1;
                @(negedge clk);
            end
            check("rst8_no_done", saw_done, 0);
        end
        run_fill("after_rst", vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
